// File: rtl/bldc_hall_decoder.sv
// ---------------------------------------------------------------------------
// bldc_hall_decoder
//   Turns the three Hall sensors of a BLDC motor into the six-step electrical
//   phase number (1..6, 0 = unknown). It also reports the rotation direction,
//   the step period and stall/error status.
//
//   Parameters
//     DEBOUNCE_CYCLES  stable synchronized cycles needed to accept a code (>=1)
//     PERIOD_W         width of the period counter and period_o
//
//   Ports
//     clk_i           system clock
//     rst_ni          asynchronous active-low reset (released synchronously)
//     ena_i           decoder enable; low forces IDLE and clears outputs
//     hall_i[2:0]     raw Hall inputs {A,B,C}, asynchronous to clk_i
//     phase_o[2:0]    accepted phase, 0 = unknown, 1..6
//     step_o          one-cycle pulse on every accepted legal phase change
//     dir_o           1 = forward (P_n -> P_n+1), 0 = reverse
//     period_o        cycles between the last two accepted steps
//     period_valid_o  period_o holds a real measurement
//     stall_o         no step seen for 2^PERIOD_W-1 cycles
//     err_o           one-cycle pulse on an illegal code or a skipped step
// ---------------------------------------------------------------------------
module bldc_hall_decoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PERIOD_W        = 24
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ena_i,
  input  logic [2:0]          hall_i,
  output logic [2:0]          phase_o,
  output logic                step_o,
  output logic                dir_o,
  output logic [PERIOD_W-1:0] period_o,
  output logic                period_valid_o,
  output logic                stall_o,
  output logic                err_o
);

  localparam int                 CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]    DB_LIMIT  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [PERIOD_W-1:0] PCNT_MAX  = '1;
  localparam logic [PERIOD_W-1:0] PCNT_LAST = PCNT_MAX - PERIOD_W'(1);

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_t;

  function automatic logic [2:0] code_to_phase(input logic [2:0] code);
    case (code)
      3'b101:  return 3'd1;
      3'b100:  return 3'd2;
      3'b110:  return 3'd3;
      3'b010:  return 3'd4;
      3'b011:  return 3'd5;
      3'b001:  return 3'd6;
      default: return 3'd0;  // 000 and 111 are illegal
    endcase
  endfunction

  // Reset asserts immediately but is released only on a clock edge.
  logic [1:0] rst_sync_reg;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_reg <= '0;
    else         rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end

  assign rst_n = rst_sync_reg[1];

  // Two-flop synchronizer on the Hall bits.
  logic [2:0] sync1_reg;
  logic [2:0] sync2_reg;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= hall_i;
      sync2_reg <= sync1_reg;
    end
  end

  // Debounce: a new code must sit unchanged for DEBOUNCE_CYCLES cycles.
  logic [2:0]       cand_reg;
  logic [2:0]       acc_reg;
  logic [CNT_W-1:0] db_cnt_reg;
  logic             accept;

  assign accept = ena_i && (sync2_reg != acc_reg) && (sync2_reg == cand_reg) &&
                  (db_cnt_reg == DB_LIMIT);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cand_reg   <= '0;
      acc_reg    <= '0;
      db_cnt_reg <= '0;
    end else if (!ena_i) begin
      cand_reg   <= '0;
      acc_reg    <= '0;
      db_cnt_reg <= '0;
    end else if (sync2_reg == acc_reg) begin
      // Dropping a glitched candidate keeps the next real change at the
      // same latency as any other.
      db_cnt_reg <= '0;
      cand_reg   <= acc_reg;
    end else if (sync2_reg != cand_reg) begin
      cand_reg   <= sync2_reg;
      db_cnt_reg <= CNT_W'(1);
    end else if (db_cnt_reg == DB_LIMIT) begin
      acc_reg    <= cand_reg;
      db_cnt_reg <= '0;
    end else begin
      db_cnt_reg <= db_cnt_reg + CNT_W'(1);
    end
  end

  // Phase arithmetic on the 1..6 ring.
  logic [2:0] new_phase;
  logic [2:0] fwd_phase;
  logic [2:0] rev_phase;

  assign new_phase = code_to_phase(cand_reg);
  assign fwd_phase = (phase_o == 3'd6) ? 3'd1 : phase_o + 3'd1;
  assign rev_phase = (phase_o == 3'd1) ? 3'd6 : phase_o - 3'd1;

  // Tracking state machine with registered outputs.
  state_t              state_reg;
  logic [PERIOD_W-1:0] pcnt_reg;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      pcnt_reg       <= '0;
      phase_o        <= '0;
      step_o         <= 1'b0;
      dir_o          <= 1'b1;
      period_o       <= '0;
      period_valid_o <= 1'b0;
      stall_o        <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      step_o <= 1'b0;
      err_o  <= 1'b0;
      if (!ena_i) begin
        state_reg      <= IDLE;
        pcnt_reg       <= '0;
        phase_o        <= '0;
        dir_o          <= 1'b1;
        period_o       <= '0;
        period_valid_o <= 1'b0;
        stall_o        <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: state_reg <= ACQUIRE;

          ACQUIRE: begin
            if (accept) begin
              if (new_phase != 3'd0) begin
                phase_o   <= new_phase;
                step_o    <= 1'b1;
                pcnt_reg  <= '0;
                state_reg <= TRACK;
              end else begin
                phase_o <= '0;
                err_o   <= 1'b1;
              end
            end
          end

          TRACK: begin
            if (accept) begin
              if (new_phase == 3'd0) begin
                phase_o        <= '0;
                err_o          <= 1'b1;
                period_valid_o <= 1'b0;
                state_reg      <= ACQUIRE;
              end else if (new_phase == fwd_phase || new_phase == rev_phase) begin
                dir_o          <= (new_phase == fwd_phase);
                phase_o        <= new_phase;
                step_o         <= 1'b1;
                period_o       <= pcnt_reg + PERIOD_W'(1);
                period_valid_o <= 1'b1;
                pcnt_reg       <= '0;
                stall_o        <= 1'b0;
              end else begin
                // Skipped step: report both the error and the new step, then
                // re-acquire so the next step does not produce a period.
                phase_o        <= new_phase;
                err_o          <= 1'b1;
                step_o         <= 1'b1;
                period_valid_o <= 1'b0;
                pcnt_reg       <= '0;
                state_reg      <= ACQUIRE;
              end
            end else if (pcnt_reg == PCNT_LAST) begin
              pcnt_reg       <= PCNT_MAX;
              stall_o        <= 1'b1;
              period_valid_o <= 1'b0;
              state_reg      <= ACQUIRE;
            end else begin
              pcnt_reg <= pcnt_reg + PERIOD_W'(1);
            end
          end

          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule
